// File: rtl/cplx_fp8_to_fp4_requant.sv
// ----------------------------------------------------------------------------
// cplx_fp8_to_fp4_requant
//   Streaming requantizer: complex FP8 (E4M3, bias 7) -> complex FP4 (E2M1,
//   bias 1). Magnitudes round to nearest with ties to even, and saturate at
//   6.0. Each sample carries per-component overflow/underflow flags. The
//   datapath is an elastic 2-stage valid/ready pipeline.
//
//   Optional feature macro: REQUANT_STATS_EN
//     defined   : ovf_cnt/unf_cnt are CNT_W-bit saturating transfer counters
//     undefined : counter logic removed, ovf_cnt/unf_cnt tied to 0
//
// Parameters
//   CNT_W          width of each statistics counter
//   FLUSH_NEG_ZERO 1: a result that rounds to zero is emitted as +0
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data = {re[7:0], im[7:0]} FP8
//   out_valid/out_ready output handshake; out_data = {re[3:0], im[3:0]} FP4
//   out_ovf, out_unf    {re,im} saturated / nonzero-rounded-to-zero flags
//   stat_clr            synchronous clear of ovf_sticky and counters
//   ovf_sticky          set by any transferred sample with an ovf bit
//   ovf_cnt, unf_cnt    transferred samples with any ovf / unf bit set
// ----------------------------------------------------------------------------

package cplx_fp8_to_fp4_requant_pkg;

  localparam int unsigned FP8_W = 8;
  localparam int unsigned FP4_W = 4;
  localparam int unsigned IN_W  = 2 * FP8_W;
  localparam int unsigned OUT_W = 2 * FP4_W;

  // Rounding decision for one component; mag is the FP4 {e[1:0], m} code.
  typedef struct packed {
    logic       sign;
    logic [2:0] mag;
    logic       ovf;
    logic       unf;
  } comp_t;

  typedef struct packed {
    comp_t re;
    comp_t im;
  } cplx_t;

endpackage

module cplx_fp8_to_fp4_requant
  import cplx_fp8_to_fp4_requant_pkg::*;
#(
  parameter int unsigned CNT_W          = 16,
  parameter bit          FLUSH_NEG_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_ovf,
  output logic [1:0]       out_unf,
  input  logic             stat_clr,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  // Classify one FP8 code by exponent band and round its magnitude to FP4.
  //   e >= 10      : |x| >= 8, always saturates
  //   e in 7..9    : |x| in [1,8), FP4 normal; keep m[2], RNE on m[1:0]
  //   e == 6       : |x| in [0.5,1), result 0.5 or 1.0 (0.75 ties up to even)
  //   e == 5       : |x| in [0.25,0.5), 0.25 ties down to 0, else 0.5
  //   e <= 4       : |x| < 0.25, rounds to zero (includes subnormals)
  function automatic comp_t classify(input logic [FP8_W-1:0] x);
    logic [3:0] e;
    logic [2:0] m;
    logic [2:0] e4;
    logic       m4;
    logic       up;
    comp_t      r;
    e      = x[6:3];
    m      = x[2:0];
    e4     = 3'd0;
    m4     = 1'b0;
    up     = 1'b0;
    r.sign = x[7];
    r.mag  = 3'd0;
    r.ovf  = 1'b0;
    r.unf  = 1'b0;
    if (e >= 4'd10) begin
      r.mag = 3'b111;
      r.ovf = 1'b1;
    end else if (e >= 4'd7) begin
      // e4 carries one headroom bit so a mantissa carry out of 6.0 shows up
      e4 = 3'(e - 4'd6);
      m4 = m[2];
      up = m[1] & (m[0] | m[2]);
      if (up) begin
        if (m4) begin
          m4 = 1'b0;
          e4 = e4 + 3'd1;
        end else begin
          m4 = 1'b1;
        end
      end
      if (e4 > 3'd3) begin
        r.mag = 3'b111;
        r.ovf = 1'b1;
      end else begin
        r.mag = {e4[1:0], m4};
      end
    end else if (e == 4'd6) begin
      r.mag = m[2] ? 3'b010 : 3'b001;
    end else if (e == 4'd5) begin
      r.mag = (m != 3'd0) ? 3'b001 : 3'b000;
      r.unf = (m == 3'd0);
    end else begin
      r.unf = (x[6:0] != 7'd0);
    end
    return r;
  endfunction

  // Final FP4 code; a zero magnitude optionally drops the input sign.
  function automatic logic [FP4_W-1:0] pack_fp4(input comp_t c);
    logic s;
    s = c.sign & ~(FLUSH_NEG_ZERO && (c.mag == 3'd0));
    return {s, c.mag};
  endfunction

  cplx_t s1_d;
  cplx_t s1_q;
  logic  s1_v;
  logic  s2_v;
  logic  s2_load;
  logic  xfer;

  // Handshake: each stage loads when empty or when its contents move on.
  assign s2_load   = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_load;
  assign out_valid = s2_v;
  assign xfer      = s2_v && out_ready;

  // Round decision for both components of the incoming sample.
  always_comb begin
    s1_d    = '0;
    s1_d.re = classify(in_data[IN_W-1:FP8_W]);
    s1_d.im = classify(in_data[FP8_W-1:0]);
  end

  // Stage 1: classified input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2: output registers, held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v     <= 1'b0;
      out_data <= '0;
      out_ovf  <= '0;
      out_unf  <= '0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_data <= {pack_fp4(s1_q.re), pack_fp4(s1_q.im)};
        out_ovf  <= {s1_q.re.ovf, s1_q.im.ovf};
        out_unf  <= {s1_q.re.unf, s1_q.im.unf};
      end
    end
  end

  // Sticky overflow indication, updated on output transfer; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (stat_clr) begin
      ovf_sticky <= 1'b0;
    end else if (xfer && (out_ovf != 2'b00)) begin
      ovf_sticky <= 1'b1;
    end
  end

`ifdef REQUANT_STATS_EN
  logic [CNT_W-1:0] ovf_cnt_q;
  logic [CNT_W-1:0] unf_cnt_q;

  // Saturating per-transfer counters; clear wins over a coincident transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (stat_clr) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (xfer) begin
      if ((out_ovf != 2'b00) && (ovf_cnt_q != {CNT_W{1'b1}})) begin
        ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
      end
      if ((out_unf != 2'b00) && (unf_cnt_q != {CNT_W{1'b1}})) begin
        unf_cnt_q <= unf_cnt_q + CNT_W'(1);
      end
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign unf_cnt = unf_cnt_q;
`else
  assign ovf_cnt = '0;
  assign unf_cnt = '0;
`endif

endmodule

// File: tb/tb_cplx_fp8_to_fp4_requant.sv
// ----------------------------------------------------------------------------
// tb_cplx_fp8_to_fp4_requant
//   Randomized and directed stimulus against a value-level reference model:
//   each FP8 code is converted to its exact magnitude and matched to the
//   nearest FP4 grid point. Outputs are compared on every falling edge.
// ----------------------------------------------------------------------------

module tb_cplx_fp8_to_fp4_requant;

  localparam int unsigned TB_CNT_W = 4;
  localparam bit          FLUSH    = 1'b1;
`ifdef REQUANT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

  logic                clk       = 1'b0;
  logic                rst       = 1'b1;
  logic                in_valid  = 1'b0;
  logic [15:0]         in_data   = '0;
  logic                out_ready = 1'b0;
  logic                stat_clr  = 1'b0;
  logic                in_ready;
  logic                out_valid;
  logic [7:0]          out_data;
  logic [1:0]          out_ovf;
  logic [1:0]          out_unf;
  logic                ovf_sticky;
  logic [TB_CNT_W-1:0] ovf_cnt;
  logic [TB_CNT_W-1:0] unf_cnt;

  cplx_fp8_to_fp4_requant #(
    .CNT_W          (TB_CNT_W),
    .FLUSH_NEG_ZERO (FLUSH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .stat_clr   (stat_clr),
    .ovf_sticky (ovf_sticky),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ovf;
    logic [1:0] unf;
    int         k;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         errors   = 0;
  int         edge_n   = 0;
  int         m_ovf_n  = 0;
  int         m_unf_n  = 0;
  bit         m_sticky = 1'b0;
  logic [7:0] last_data = '0;
  logic [1:0] last_ovf  = '0;
  logic [1:0] last_unf  = '0;

  // Hand-computed pins: FP8 code -> FP4 code, ovf, unf.
  localparam int NPIN = 14;
  logic [7:0] pin_in  [NPIN] = '{8'h3E, 8'h3A, 8'h30, 8'h2C, 8'h28, 8'h01, 8'h4E,
                                 8'h4D, 8'hFF, 8'h38, 8'hB8, 8'h80, 8'hB0, 8'hA8};
  logic [3:0] pin_out [NPIN] = '{4'h4, 4'h2, 4'h1, 4'h1, 4'h0, 4'h0, 4'h7,
                                 4'h7, 4'hF, 4'h2, 4'hA, 4'h0, 4'h9, 4'h0};
  logic       pin_ovf [NPIN] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
  logic       pin_unf [NPIN] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact magnitude in units of 2^-9, nearest of the FP4 grid plus
  // 8.0 (first point past 6.0); ties pick the even mantissa. Returns
  // {fp4_code[3:0], ovf, unf}.
  function automatic logic [5:0] model_fp4(input logic [7:0] x);
    int   tab[9];
    int   e, m, v, best, bd, d;
    logic s;
    tab  = '{0, 256, 512, 768, 1024, 1536, 2048, 3072, 4096};
    e    = int'(x[6:3]);
    m    = int'(x[2:0]);
    v    = (e == 0) ? m : ((8 + m) << (e - 1));
    best = 0;
    bd   = 32'h7fffffff;
    for (int c = 0; c < 9; c++) begin
      d = (v > tab[c]) ? (v - tab[c]) : (tab[c] - v);
      if ((d < bd) || ((d == bd) && ((c % 2) == 0))) begin
        best = c;
        bd   = d;
      end
    end
    s = (best == 0 && FLUSH) ? 1'b0 : x[7];
    return {s, (best == 8) ? 3'd7 : 3'(best), best == 8, (v != 0) && (best == 0)};
  endfunction

  // Compare process: check outputs against the model, then account for what
  // the coming rising edge will do.
  always @(negedge clk) begin
    logic [5:0] r;
    logic [5:0] im;
    bit         ev;
    if (rst) begin
      q.delete();
      m_ovf_n  = 0;
      m_unf_n  = 0;
      m_sticky = 1'b0;
    end
    ev = (q.size() != 0) && (edge_n >= q[0].k + 1);
    chk("out_valid", out_valid, ev);
    if (rst) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_out_flags", {out_ovf, out_unf}, 0);
    end else begin
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    end
    if (ev) begin
      chk("out_data", out_data, q[0].data);
      chk("out_ovf", out_ovf, q[0].ovf);
      chk("out_unf", out_unf, q[0].unf);
    end
    chk("ovf_sticky", ovf_sticky, m_sticky);
    chk("ovf_cnt", ovf_cnt, STATS ? m_ovf_n : 0);
    chk("unf_cnt", unf_cnt, STATS ? m_unf_n : 0);
    if (!rst) begin
      if (ev && out_ready) begin
        last_data = out_data;
        last_ovf  = out_ovf;
        last_unf  = out_unf;
        if (!stat_clr) begin
          if (q[0].ovf != 2'b00) begin
            m_sticky = 1'b1;
            if (m_ovf_n < CNT_MAX) m_ovf_n++;
          end
          if (q[0].unf != 2'b00 && m_unf_n < CNT_MAX) m_unf_n++;
        end
        void'(q.pop_front());
      end
      if (stat_clr) begin
        m_ovf_n  = 0;
        m_unf_n  = 0;
        m_sticky = 1'b0;
      end
      if (in_valid && in_ready) begin
        r  = model_fp4(in_data[15:8]);
        im = model_fp4(in_data[7:0]);
        q.push_back('{{r[5:2], im[5:2]}, {r[1], im[1]}, {r[0], im[0]}, edge_n + 1});
      end
    end
    edge_n++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one sample until accepted; out_ready high with probability pct%.
  task automatic send(input logic [15:0] d, input int pct);
    bit acc;
    int n;
    n        = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      out_ready = ($urandom_range(0, 99) < pct);
      #1 acc = in_ready;
      cyc();
      n++;
    end while (!acc && n < 100);
    chk("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Model pinned to hand-derived values.
    for (int p = 0; p < NPIN; p++) begin
      chk($sformatf("model_%02h", pin_in[p]), model_fp4(pin_in[p]),
          {pin_out[p], pin_ovf[p], pin_unf[p]});
    end

    // Reset state.
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_sticky", ovf_sticky, 0);
    chk("reset_ovf_cnt", ovf_cnt, 0);

    // (+1.0, -1.0) with idle downstream: 2-cycle latency, 0x2A.
    in_valid  = 1'b1;
    in_data   = 16'h38B8;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t1_valid_early", out_valid, 0);
    cyc();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'h2A);
    chk("t1_flags", {out_ovf, out_unf}, 0);
    drain();

    // Sweep all FP8 codes on re, random im.
    for (int c = 0; c < 256; c++) send({8'(c), 8'($urandom)}, 100);
    drain();

    // Directed boundary pins through the DUT.
    for (int p = 0; p < NPIN; p++) begin
      send({pin_in[p], 8'h38}, 100);
      drain();
      chk($sformatf("pin_%02h_data", pin_in[p]), last_data[7:4], pin_out[p]);
      chk($sformatf("pin_%02h_ovf", pin_in[p]), last_ovf[1], pin_ovf[p]);
      chk($sformatf("pin_%02h_unf", pin_in[p]), last_unf[1], pin_unf[p]);
    end
    chk("sticky_after_ovf", ovf_sticky, 1);

    // Random stream with random backpressure and idle gaps.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        out_ready = $urandom_range(0, 1) == 1;
        cyc();
      end
      send(16'($urandom), 50);
    end
    drain();

    // Statistics: clear, three ovf, then clear coincident with a fourth.
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    chk("clr_ovf_cnt", ovf_cnt, 0);
    chk("clr_sticky", ovf_sticky, 0);
    repeat (3) send({8'h7F, 8'h38}, 100);
    drain();
    chk("stats_3_cnt", ovf_cnt, STATS ? 3 : 0);
    chk("stats_3_sticky", ovf_sticky, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {8'h7F, 8'h38};
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("stall_valid", out_valid, 1);
    out_ready = 1'b1;
    stat_clr  = 1'b1;
    cyc();
    stat_clr = 1'b0;
    chk("clr_win_cnt", ovf_cnt, 0);
    chk("clr_win_sticky", ovf_sticky, 0);
    chk("clr_win_drained", out_valid, 0);
    repeat (20) send({8'hC8, 8'h7F}, 100);
    drain();
    chk("stats_sat_cnt", ovf_cnt, STATS ? CNT_MAX : 0);
    chk("stats_sat_sticky", ovf_sticky, 1);

    // Reset with both stages full.
    send({8'h3E, 8'h3A}, 0);
    send({8'h30, 8'h2C}, 0);
    in_valid  = 1'b1;
    in_data   = 16'h4E4D;
    out_ready = 1'b0;
    #1 chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    rst = 1'b1;
    #1 chk("rst_immediate_valid", out_valid, 0);
    in_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_data", out_data, 0);
    chk("post_rst_sticky", ovf_sticky, 0);
    chk("post_rst_cnt", ovf_cnt, 0);
    in_valid  = 1'b1;
    in_data   = 16'h38B8;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("post_rst_lat1", out_valid, 0);
    cyc();
    chk("post_rst_lat2", out_valid, 1);
    chk("post_rst_out", out_data, 8'h2A);
    drain();

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
